switch_debouncer: RTL

//   Input conditioner between the Nexys3 slide switches/buttons and the gate-logic stage.
//   Per channel:
//     - synchronises the asynchronous raw input (2 flip-flops);
//     - filters bounce with a saturating stability counter;
//     - drives a clean level plus one-cycle rise/fall pulses.
//   Its sw_db outputs feed the a/b operands of the combinational gate block and the LED bank.

---
 rtl/switch_debouncer.sv | 110 +++++++++++
 1 files changed

// File: rtl/switch_debouncer.sv
// Per-channel switch/button conditioner: 2-FF synchroniser, saturating stability counter, clean level with rise/fall pulses.
// Optional SWITCH_DEBOUNCER_TOGGLE_EN adds a per-channel toggle flop that flips on every rise.
module switch_debouncer #(
  parameter int N_CH      = 2,
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] sw_raw,
  output logic [N_CH-1:0] sw_db,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] tgl
);

  // state | meaning
  // IDLE  | s2 agrees with sw_db, counter parked at 0
  // QUAL  | s2 differs from sw_db, counter qualifying the new level
  typedef enum logic {IDLE, QUAL} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [N_CH-1:0] s1;
  logic [N_CH-1:0] s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             db_q;
    logic             rise_q;
    logic             fall_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        state  <= IDLE;
        cnt    <= '0;
        db_q   <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        case (state)
          IDLE: begin
            if (s2[i] != db_q) begin
              state <= QUAL;
              cnt   <= CNT_ONE;
            end else begin
              cnt <= '0;
            end
          end
          QUAL: begin
            if (s2[i] == db_q) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              // accept the new level and pulse in the same edge
              state  <= IDLE;
              cnt    <= '0;
              db_q   <= s2[i];
              rise_q <= s2[i];
              fall_q <= ~s2[i];
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign sw_db[i] = db_q;
    assign rise[i]  = rise_q;
    assign fall[i]  = fall_q;
    assign busy[i]  = (state == QUAL);

`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
    logic tgl_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        tgl_q <= 1'b0;
      end else if (rise_q) begin
        tgl_q <= ~tgl_q;
      end
    end

    assign tgl[i] = tgl_q;
`else
    assign tgl[i] = 1'b0;
`endif
  end

endmodule
